// File: rtl/pc_unit.sv
// pc_unit: program-counter sequencer with increment, jump, branch and a call/return stack
module pc_unit #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 4,
  parameter logic [WIDTH-1:0] RESET_VECTOR = '0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             jump,
  input  logic             branch,
  input  logic             call,
  input  logic             ret,
  input  logic [WIDTH-1:0] target,
  input  logic [WIDTH-1:0] offset,
  output logic [WIDTH-1:0] pc,
  output logic             stack_full,
  output logic             stack_empty,
  output logic             stack_err
);
  localparam int SPW = $clog2(DEPTH) + 1;
  logic [WIDTH-1:0] pc_q, pc_d;
  logic [SPW-1:0]   sp_q, sp_d;
  logic             err_q, err_d, push;
  logic [WIDTH-1:0] stack_q [DEPTH];
  logic [SPW-2:0]   top_idx;
  assign top_idx     = sp_q[SPW-2:0] - 1'b1;
  assign stack_full  = sp_q == SPW'(DEPTH);
  assign stack_empty = sp_q == '0;
  assign pc          = pc_q;
  assign stack_err   = err_q;
  // ret beats call, so a simultaneous call+ret never pushes
  always_comb begin
    pc_d  = pc_q;
    sp_d  = sp_q;
    err_d = err_q;
    push  = 1'b0;
    if (en) begin
      if (ret) begin
        if (stack_empty) err_d = 1'b1;
        else begin
          pc_d = stack_q[top_idx];
          sp_d = sp_q - 1'b1;
        end
      end else if (call) begin
        if (stack_full) err_d = 1'b1;
        else begin
          push = 1'b1;
          pc_d = target;
          sp_d = sp_q + 1'b1;
        end
      end else begin
        pc_d = jump ? target : branch ? pc_q + offset : pc_q + 1'b1;
      end
    end
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      pc_q  <= RESET_VECTOR;
      sp_q  <= '0;
      err_q <= 1'b0;
    end else begin
      pc_q  <= pc_d;
      sp_q  <= sp_d;
      err_q <= err_d;
    end
  end
  always_ff @(posedge clk) begin
    if (push && !reset) stack_q[sp_q[SPW-2:0]] <= pc_q + 1'b1;
  end
endmodule

// File: tb/tb_pc_unit.sv
// tb_pc_unit: directed self-checking bench for pc_unit
module tb_pc_unit;
  logic        clk = 1'b0;
  logic        reset, en, jump, branch, call, ret;
  logic [15:0] target, offset, pc;
  logic        stack_full, stack_empty, stack_err;
  int          n_chk = 0;
  int          n_fail = 0;

  pc_unit dut (
    .clk(clk), .reset(reset), .en(en), .jump(jump), .branch(branch),
    .call(call), .ret(ret), .target(target), .offset(offset), .pc(pc),
    .stack_full(stack_full), .stack_empty(stack_empty), .stack_err(stack_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_jump(input logic [15:0] t);
    jump = 1'b1; target = t;
    step();
    jump = 1'b0;
  endtask

  logic [15:0] ret_exp [4];

  initial begin
    reset = 1'b1; en = 1'b0; jump = 1'b0; branch = 1'b0; call = 1'b0; ret = 1'b0;
    target = '0; offset = '0;
    step();
    chk("reset_pc", pc, 16'h0000);
    chk("reset_empty", stack_empty, 1);
    chk("reset_full", stack_full, 0);
    chk("reset_err", stack_err, 0);

    reset = 1'b0; en = 1'b1;
    for (int i = 1; i <= 5; i++) begin
      step();
      chk("inc_pc", pc, 32'(i));
    end
    chk("inc_empty", stack_empty, 1);
    chk("inc_err", stack_err, 0);

    do_jump(16'h0010);
    chk("jump_0010", pc, 16'h0010);
    en = 1'b0; jump = 1'b1; target = 16'h1234;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("stall_pc", pc, 16'h0010);
    end
    en = 1'b1;
    step();
    chk("jump_1234", pc, 16'h1234);
    jump = 1'b0;

    do_jump(16'h0100);
    branch = 1'b1; offset = 16'hFFFC;
    step();
    chk("branch_back", pc, 16'h00FC);
    branch = 1'b0;
    do_jump(16'hFFFF);
    step();
    chk("inc_wrap", pc, 16'h0000);

    do_jump(16'h0020);
    call = 1'b1; target = 16'h0200;
    step();
    call = 1'b0;
    chk("call_pc", pc, 16'h0200);
    chk("call_not_empty", stack_empty, 0);
    step();
    chk("sub_inc1", pc, 16'h0201);
    step();
    chk("sub_inc2", pc, 16'h0202);
    ret = 1'b1;
    step();
    ret = 1'b0;
    chk("ret_pc", pc, 16'h0021);
    chk("ret_empty", stack_empty, 1);

    do_jump(16'h0030);
    ret_exp = '{16'h0031, 16'h0301, 16'h0311, 16'h0321};
    call = 1'b1;
    for (int i = 0; i < 4; i++) begin
      target = 16'h0300 + 16'(i * 16);
      step();
      chk("fill_pc", pc, target);
    end
    chk("fill_full", stack_full, 1);
    chk("fill_err", stack_err, 0);
    target = 16'h0400;
    step();
    call = 1'b0;
    chk("overflow_pc", pc, 16'h0330);
    chk("overflow_err", stack_err, 1);
    chk("overflow_full", stack_full, 1);
    ret = 1'b1;
    for (int i = 3; i >= 0; i--) begin
      step();
      chk("unwind_pc", pc, ret_exp[i]);
    end
    chk("unwind_empty", stack_empty, 1);
    step();
    ret = 1'b0;
    chk("underflow_pc", pc, 16'h0031);
    chk("underflow_err", stack_err, 1);

    call = 1'b1; target = 16'h0500;
    step();
    chk("one_push_pc", pc, 16'h0500);
    ret = 1'b1; target = 16'h0700;
    step();
    chk("callret_pc", pc, 16'h0032);
    chk("callret_empty", stack_empty, 1);
    call = 1'b0;
    step();
    ret = 1'b0;
    chk("callret_nopush_pc", pc, 16'h0032);
    reset = 1'b1; call = 1'b1; target = 16'h0600;
    step();
    chk("rst_call_pc", pc, 16'h0000);
    chk("rst_call_empty", stack_empty, 1);
    chk("rst_call_full", stack_full, 0);
    chk("rst_call_err", stack_err, 0);
    reset = 1'b0;
    step();
    call = 1'b0;
    chk("post_rst_call_pc", pc, 16'h0600);
    chk("post_rst_call_empty", stack_empty, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
